// File: rtl/spike_scheduler.sv
// spike_scheduler: per-core time-slot spike buffer.
// Router packets (axon index + delay) set a bit in a circular array of slot
// bitmaps; every global tick releases the current slot to the neuron core as
// a one-cycle pulse, clears it and advances the slot pointer.
module spike_scheduler #(
  parameter int NUM_AXONS = 256,
  parameter int NUM_SLOTS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pkt_i,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic                 tick_i,
  output logic [NUM_AXONS-1:0] axon_spikes_o,
  output logic                 axon_valid_o,
  output logic [3:0]           cur_slot_o,
  output logic [15:0]          drop_count_o
);

  // A single-slot buffer still needs a one-bit pointer; it is masked to zero.
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SW-1:0] SLOT_MASK = SW'(NUM_SLOTS - 1);

  logic [NUM_AXONS-1:0] slots [NUM_SLOTS];
  logic [SW-1:0]        cur_slot;
  logic [7:0]           axon;
  logic [3:0]           dt;
  logic                 accept;
  logic                 drop;
  logic [SW-1:0]        target_slot;
  logic [NUM_AXONS-1:0] axon_onehot;
  logic                 unused_reserved;

  assign axon            = pkt_i[11:4];
  assign dt              = pkt_i[3:0];
  assign unused_reserved = ^pkt_i[31:12];

  // Ticks always win over packets, so ready drops combinationally with tick_i.
  assign pkt_ready_o = rst & ~tick_i;
  assign accept      = pkt_valid_i & pkt_ready_o;

  // Out-of-range axons and delays beyond the slot ring are consumed but dropped.
  assign drop = ({1'b0, axon} >= 9'(NUM_AXONS)) || ({1'b0, dt} >= 5'(NUM_SLOTS));

  assign target_slot = (cur_slot + dt[SW-1:0]) & SLOT_MASK;
  assign cur_slot_o  = 4'(cur_slot);

  // Decode the packet's axon index into a single-bit mask over the core's axons.
  always_comb begin
    axon_onehot = '0;
    for (int i = 0; i < NUM_AXONS; i++) begin
      axon_onehot[i] = (axon == 8'(i));
    end
  end

  // Slot storage, pointer and release outputs: tick releases/clears, else packets OR in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slots[s] <= '0;
      end
      cur_slot      <= '0;
      axon_spikes_o <= '0;
      axon_valid_o  <= 1'b0;
    end else begin
      axon_valid_o <= 1'b0;
      if (tick_i) begin
        axon_spikes_o   <= slots[cur_slot];
        axon_valid_o    <= 1'b1;
        slots[cur_slot] <= '0;
        cur_slot        <= (cur_slot + SW'(1)) & SLOT_MASK;
      end else if (accept && !drop) begin
        slots[target_slot] <= slots[target_slot] | axon_onehot;
      end
    end
  end

  // Saturating count of packets that were consumed without setting a bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_count_o <= '0;
    end else if (accept && drop && (drop_count_o != 16'hFFFF)) begin
      drop_count_o <= drop_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_spike_scheduler.sv
// tb_spike_scheduler: drives two scheduler instances (256x16 and 200x8) with
// shared directed + random traffic. A reference model tracks pending spikes
// by absolute release tick; a negedge monitor pops expected releases from a
// scoreboard queue per instance and compares them with the DUT outputs.
module tb_spike_scheduler;

  localparam int NA0 = 256;
  localparam int NS0 = 16;
  localparam int NA1 = 200;
  localparam int NS1 = 8;

  typedef struct {
    logic [255:0] vec;
    int           slot;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [31:0]    pkt;
  logic           pkt_valid;
  logic           tick;

  logic           ready0, ready1;
  logic [NA0-1:0] spikes0;
  logic [NA1-1:0] spikes1;
  logic           valid0, valid1;
  logic [3:0]     cur0, cur1;
  logic [15:0]    drops0, drops1;

  int             total = 0;
  int             bad = 0;
  bit             mon_en = 0;

  // Reference model state, indexed by instance.
  logic [255:0]   pend [longint];
  int             tcount [2];
  int             mdrops [2];
  logic [255:0]   last [2];
  exp_t           q0 [$];
  exp_t           q1 [$];

  spike_scheduler #(.NUM_AXONS(NA0), .NUM_SLOTS(NS0)) dut0 (
    .clk(clk), .rst(rst), .pkt_i(pkt), .pkt_valid_i(pkt_valid),
    .pkt_ready_o(ready0), .tick_i(tick), .axon_spikes_o(spikes0),
    .axon_valid_o(valid0), .cur_slot_o(cur0), .drop_count_o(drops0)
  );

  spike_scheduler #(.NUM_AXONS(NA1), .NUM_SLOTS(NS1)) dut1 (
    .clk(clk), .rst(rst), .pkt_i(pkt), .pkt_valid_i(pkt_valid),
    .pkt_ready_o(ready1), .tick_i(tick), .axon_spikes_o(spikes1),
    .axon_valid_o(valid1), .cur_slot_o(cur1), .drop_count_o(drops1)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int na(input int inst);
    return (inst == 0) ? NA0 : NA1;
  endfunction

  function automatic int ns(input int inst);
    return (inst == 0) ? NS0 : NS1;
  endfunction

  function automatic longint pkey(input int inst, input int t);
    return (longint'(inst) << 32) + longint'(t);
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s inst%0d: got %0h want %0h", name, inst, got, want);
    end
  endtask

  // Apply the rules of one clock edge to the model of one instance.
  task automatic modelInst(input int inst, input logic r, input logic v,
                           input logic [31:0] p, input logic tk);
    int           axon;
    int           dt;
    longint       k;
    logic [255:0] vec;
    logic [255:0] one;
    exp_t         e;
    if (!r) begin
      for (int t = 0; t <= tcount[inst] + 16; t++) begin
        k = pkey(inst, t);
        if (pend.exists(k)) pend.delete(k);
      end
      tcount[inst] = 0;
      mdrops[inst] = 0;
      last[inst]   = '0;
    end else if (tk) begin
      k   = pkey(inst, tcount[inst]);
      vec = pend.exists(k) ? pend[k] : '0;
      if (pend.exists(k)) pend.delete(k);
      e.vec  = vec;
      e.slot = (tcount[inst] + 1) % ns(inst);
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
      last[inst] = vec;
      tcount[inst]++;
    end else if (v) begin
      axon = int'(p[11:4]);
      dt   = int'(p[3:0]);
      if (axon >= na(inst) || dt >= ns(inst)) begin
        if (mdrops[inst] < 65535) mdrops[inst]++;
      end else begin
        k   = pkey(inst, tcount[inst] + dt);
        one = 256'd1 << axon;
        pend[k] = (pend.exists(k) ? pend[k] : 256'd0) | one;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input logic r, input logic v, input int axon,
                               input int dt, input logic tk);
    rst       = r;
    pkt_valid = v;
    pkt       = {12'($urandom), 8'(axon), 4'(dt)} ;
    pkt[31:12] = 20'($urandom);
    tick      = tk;
    @(posedge clk);
    modelInst(0, r, v, pkt, tk);
    modelInst(1, r, v, pkt, tk);
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic doTick();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic sendPkt(input int axon, input int dt);
    applyStimulus(1'b1, 1'b1, axon, dt, 1'b0);
  endtask

  // Compare one instance's outputs against the model and its scoreboard queue.
  task automatic monitorInst(input int inst, input logic v, input logic [255:0] sp,
                             input logic [3:0] cur, input logic [15:0] dc,
                             input logic rdy);
    exp_t e;
    int   qn;
    qn = (inst == 0) ? q0.size() : q1.size();
    if (v === 1'b1) begin
      if (qn == 0) begin
        checkOutput("spurious_valid", inst, 256'd1, 256'd0);
      end else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput("release_vec", inst, sp, e.vec);
        checkOutput("release_slot", inst, 256'(cur), 256'(e.slot));
      end
    end else if (qn != 0) begin
      e = (inst == 0) ? q0.pop_front() : q1.pop_front();
      checkOutput("missing_valid", inst, 256'(v), 256'd1);
    end
    checkOutput("spikes_hold", inst, sp, last[inst]);
    checkOutput("cur_slot", inst, 256'(cur), 256'(tcount[inst] % ns(inst)));
    checkOutput("drop_count", inst, 256'(dc), 256'(mdrops[inst]));
    checkOutput("pkt_ready", inst, 256'(rdy), 256'(rst & ~tick));
  endtask

  // Sample DUT outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      monitorInst(0, valid0, 256'(spikes0), cur0, drops0, ready0);
      monitorInst(1, valid1, 256'(spikes1), cur1, drops1, ready1);
    end
  end

  initial begin
    int r;
    rst = 1'b0; pkt = '0; pkt_valid = 1'b0; tick = 1'b0;
    tcount[0] = 0; tcount[1] = 0; mdrops[0] = 0; mdrops[1] = 0;
    last[0] = '0; last[1] = '0;
    doReset();
    doReset();

    // Single spike with zero delay, then an empty release.
    sendPkt(5, 0);
    doTick(); idle(1);
    doTick(); idle(1);

    // Delay of three ticks.
    doReset();
    sendPkt(10, 3);
    for (int i = 0; i < 4; i++) begin doTick(); idle(1); end

    // Delay wrapping past the end of the slot ring.
    doReset();
    for (int i = 0; i < 14; i++) doTick();
    sendPkt(7, 3);
    for (int i = 0; i < 4; i++) begin doTick(); idle(1); end

    // Packet offered during a tick waits for the next cycle.
    applyStimulus(1'b1, 1'b1, 20, 1, 1'b1);
    sendPkt(20, 1);
    doTick(); doTick(); idle(1);

    // Out-of-range axon for the narrow instance, plus merged duplicates.
    doReset();
    sendPkt(250, 0);
    sendPkt(3, 1);
    sendPkt(3, 1);
    sendPkt(4, 12);
    for (int i = 0; i < 3; i++) begin doTick(); idle(1); end

    // Reset mid-stream discards pending spikes.
    for (int i = 0; i < 6; i++) sendPkt(i * 7, i);
    doReset();
    for (int i = 0; i < 16; i++) doTick();
    idle(2);

    // Randomized traffic with occasional resets and back-to-back ticks.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 299);
      applyStimulus((r != 0), ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 255), $urandom_range(0, 15),
                    ($urandom_range(0, 5) == 0));
    end
    idle(3);

    checkOutput("queue_empty0", 0, 256'(q0.size()), 256'd0);
    checkOutput("queue_empty1", 1, 256'(q1.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
